cache_miss_ctrl: RTL and testbench
==================================

CACHE_MISS_CTRL -- requirements
Module: cache_miss_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, 5, address/tag width.
REQ-002 SHALL have parameter DATA_W, 8, data width.
REQ-003 SHALL have parameter MEM_TIMEOUT, 15, maximum cycles to wait for mem_ack_in before aborting.
REQ-004 SHALL have port clock_in  in  1  single clock; all state changes on posedge.
REQ-005 SHALL have port reset_in  in  1  asynchronous, active-high reset.
REQ-006 SHALL have CPU ports: req_valid_in in 1; req_wren_in in 1; req_addr_in in ADDR_W; req_data_in in DATA_W; req_ready_out out 1; resp_valid_out out 1; resp_data_out out DATA_W; resp_err_out out 1.
REQ-007 SHALL have cache ports: cache_hit_in in 1; cache_dirty_in in 1; cache_victim_tag_in in ADDR_W; cache_q_in in DATA_W; cache_lookup_out out 1; cache_wren_out out 1; cache_fill_out out 1; cache_addr_out out ADDR_W; cache_data_out out DATA_W.
REQ-008 SHALL have main-memory ports: mem_rd_out out 1; mem_wr_out out 1; mem_addr_out out ADDR_W; mem_data_out out DATA_W; mem_ack_in in 1; mem_q_in in DATA_W.

Function
REQ-009 SHALL implement FSM states IDLE, LOOKUP, WRITEBACK, FILL, RESPOND.
REQ-010 IDLE: req_ready_out=1; request accepted when req_valid_in&req_ready_out; addr/data/wren captured; next LOOKUP.
REQ-011 LOOKUP: cache_lookup_out=1 for exactly one cycle, cache_addr_out=captured addr; hit -> RESPOND; miss&cache_dirty_in -> WRITEBACK; miss&~dirty -> FILL.
REQ-012 Hit write: cache_wren_out=1 with cache_data_out=captured data in the LOOKUP cycle; hit read: resp_data_out=cache_q_in registered.
REQ-013 WRITEBACK: mem_wr_out=1, mem_addr_out=victim tag, mem_data_out=cache_q_in, held until mem_ack_in; then FILL.
REQ-014 FILL: mem_rd_out=1, mem_addr_out=captured addr until mem_ack_in; on ack cache_fill_out=1 one cycle with cache_data_out=mem_q_in (or captured data if write), then RESPOND.
REQ-015 RESPOND: resp_valid_out=1 for exactly one cycle; read returns hit or filled data; write returns written data; next IDLE.
REQ-016 Minimum latency accept->resp_valid_out: hit 2 cycles; clean miss 2+N+1; dirty miss 2+N1+N2+1 (N=ack wait cycles, min 1).
REQ-017 req_ready_out SHALL be 0 in all states except IDLE; req_valid_in outside IDLE ignored, no queueing.
REQ-018 mem_rd_out and mem_wr_out SHALL never be 1 in the same cycle.
REQ-019 Timeout counter SHALL count cycles in WRITEBACK/FILL, clear on state entry; reaching MEM_TIMEOUT -> RESPOND with resp_err_out=1, cache untouched.
REQ-020 mem_ack_in outside WRITEBACK/FILL SHALL be ignored.

Reset
REQ-021 reset_in SHALL force IDLE immediately, asynchronously, from any state including mid-WRITEBACK/FILL.
REQ-022 Reset values: req_ready_out=1 after release, all strobes/valids/err 0, all address/data outputs 0, timeout counter 0.
REQ-023 An aborted miss SHALL NOT produce resp_valid_out or cache_fill_out after reset release.

Configuration
REQ-024 Macro CACHE_MISS_CTRL_STATS_EN SHALL add outputs hit_cnt_out and miss_cnt_out (8 bits each, saturating at 255, reset 0), incremented on LOOKUP outcome.
REQ-025 Without CACHE_MISS_CTRL_STATS_EN the ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-026 Package cache_pkg SHALL hold the FSM state encoding, ADDR_W/DATA_W defaults and MEM_TIMEOUT default.
REQ-027 Timeout logic SHALL be sub-module mem_timeout_cnt (start, ack, expired); stats counters inline.

Verification
REQ-028 Read hit addr 5'b10100, cache_q_in=8'h3C -> resp_valid_out 2 cycles after accept, resp_data_out=8'h3C, no mem strobes.
REQ-029 Write hit addr 5'b10110 data 8'hA5 -> cache_wren_out=1 one cycle with 8'hA5, resp after 2 cycles, no mem access.
REQ-030 Clean read miss addr 5'b11001, mem acks after 3 cycles with 8'h77 -> one cache_fill_out with 8'h77, resp_data_out=8'h77, no mem_wr_out.
REQ-031 Dirty miss, victim tag 5'b10101, cache_q_in=8'h11 -> mem_wr_out addr 5'b10101 data 8'h11 until ack, then mem_rd_out, then fill and resp.
REQ-032 mem_ack_in never asserted -> after 15 cycles resp_valid_out=1, resp_err_out=1, cache_fill_out never asserted.
REQ-033 reset_in pulsed during FILL -> outputs zero same cycle, IDLE with req_ready_out=1 after release, no resp_valid_out.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: shared FSM encoding, parameter defaults and helpers for cache_miss_ctrl
package cache_pkg;
    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL, RESPOND} state_t;
    localparam int ADDR_W_DEF      = 5;
    localparam int DATA_W_DEF      = 8;
    localparam int MEM_TIMEOUT_DEF = 15;
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction
endpackage

// File: rtl/cache_miss_ctrl_timeout.sv
// mem_timeout_cnt: counts cycles spent waiting for a memory ack and flags expiry
//   clock_in, reset_in : clock, async active-high reset
//   start              : pulse on the edge entering a wait state; clears and arms the counter
//   ack                : memory ack while waiting; disarms the counter
//   expired            : high in the MEM_TIMEOUT-th cycle of a wait without ack
module mem_timeout_cnt import cache_pkg::*; #(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic clock_in,
    input  logic reset_in,
    input  logic start,
    input  logic ack,
    output logic expired
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    logic [CW-1:0] cnt;
    logic          active;
    assign expired = active && cnt == CW'(MEM_TIMEOUT - 1);
    always_ff @(posedge clock_in or posedge reset_in)
        if (reset_in) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (start) begin
            cnt    <= '0;
            active <= 1'b1;
        end else if (ack || expired) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (active) begin
            cnt    <= cnt + 1'b1;
        end
endmodule

// File: rtl/cache_miss_ctrl.sv
// cache_miss_ctrl: single-request cache controller handling hits, clean/dirty misses and memory timeouts
//   clock_in, reset_in        : clock, async active-high reset
//   req_* / resp_*            : CPU request (valid/ready) and one-cycle response with data and error
//   cache_*                   : lookup strobe, hit write, line fill; hit/dirty/victim tag/q from the array
//   mem_*                     : main-memory read/write strobes held until mem_ack_in
//   hit_cnt_out, miss_cnt_out : saturating lookup statistics, present only with CACHE_MISS_CTRL_STATS_EN
module cache_miss_ctrl import cache_pkg::*; #(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic              clock_in,
    input  logic              reset_in,
    input  logic              req_valid_in,
    input  logic              req_wren_in,
    input  logic [ADDR_W-1:0] req_addr_in,
    input  logic [DATA_W-1:0] req_data_in,
    output logic              req_ready_out,
    output logic              resp_valid_out,
    output logic [DATA_W-1:0] resp_data_out,
    output logic              resp_err_out,
    input  logic              cache_hit_in,
    input  logic              cache_dirty_in,
    input  logic [ADDR_W-1:0] cache_victim_tag_in,
    input  logic [DATA_W-1:0] cache_q_in,
    output logic              cache_lookup_out,
    output logic              cache_wren_out,
    output logic              cache_fill_out,
    output logic [ADDR_W-1:0] cache_addr_out,
    output logic [DATA_W-1:0] cache_data_out,
    output logic              mem_rd_out,
    output logic              mem_wr_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_ack_in,
    input  logic [DATA_W-1:0] mem_q_in
`ifdef CACHE_MISS_CTRL_STATS_EN
    ,
    output logic [7:0]        hit_cnt_out,
    output logic [7:0]        miss_cnt_out
`endif
);
    state_t state;
    logic   wren_q;
    logic   tmo_start;
    logic   tmo_ack;
    logic   tmo_expired;
    // cache_addr_out/cache_data_out double as the captured request address/data
    assign req_ready_out  = state == IDLE && !reset_in;
    assign cache_wren_out = state == LOOKUP && cache_hit_in && wren_q;
    assign tmo_start      = (state == LOOKUP && !cache_hit_in) || (state == WRITEBACK && mem_ack_in);
    assign tmo_ack        = mem_ack_in && (state == WRITEBACK || state == FILL);
    mem_timeout_cnt #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_tmo (
        .clock_in (clock_in),
        .reset_in (reset_in),
        .start    (tmo_start),
        .ack      (tmo_ack),
        .expired  (tmo_expired)
    );
    always_ff @(posedge clock_in or posedge reset_in)
        if (reset_in) begin
            state            <= IDLE;
            wren_q           <= 1'b0;
            resp_valid_out   <= 1'b0;
            resp_data_out    <= '0;
            resp_err_out     <= 1'b0;
            cache_lookup_out <= 1'b0;
            cache_fill_out   <= 1'b0;
            cache_addr_out   <= '0;
            cache_data_out   <= '0;
            mem_rd_out       <= 1'b0;
            mem_wr_out       <= 1'b0;
            mem_addr_out     <= '0;
            mem_data_out     <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid_in) begin
                    state            <= LOOKUP;
                    wren_q           <= req_wren_in;
                    cache_addr_out   <= req_addr_in;
                    cache_data_out   <= req_data_in;
                    cache_lookup_out <= 1'b1;
                end
                LOOKUP: begin
                    cache_lookup_out <= 1'b0;
                    if (cache_hit_in) begin
                        state          <= RESPOND;
                        resp_valid_out <= 1'b1;
                        resp_data_out  <= wren_q ? cache_data_out : cache_q_in;
                    end else if (cache_dirty_in) begin
                        state        <= WRITEBACK;
                        mem_wr_out   <= 1'b1;
                        mem_addr_out <= cache_victim_tag_in;
                        mem_data_out <= cache_q_in;
                    end else begin
                        state        <= FILL;
                        mem_rd_out   <= 1'b1;
                        mem_addr_out <= cache_addr_out;
                    end
                end
                WRITEBACK: if (mem_ack_in) begin
                    state        <= FILL;
                    mem_wr_out   <= 1'b0;
                    mem_rd_out   <= 1'b1;
                    mem_addr_out <= cache_addr_out;
                end else if (tmo_expired) begin
                    state          <= RESPOND;
                    mem_wr_out     <= 1'b0;
                    resp_valid_out <= 1'b1;
                    resp_err_out   <= 1'b1;
                    resp_data_out  <= '0;
                end
                FILL: if (mem_ack_in) begin
                    state          <= RESPOND;
                    mem_rd_out     <= 1'b0;
                    cache_fill_out <= 1'b1;
                    cache_data_out <= wren_q ? cache_data_out : mem_q_in;
                    resp_data_out  <= wren_q ? cache_data_out : mem_q_in;
                end else if (tmo_expired) begin
                    state          <= RESPOND;
                    mem_rd_out     <= 1'b0;
                    resp_valid_out <= 1'b1;
                    resp_err_out   <= 1'b1;
                    resp_data_out  <= '0;
                end
                // Fill path arrives with resp_valid low: one fill cycle, then the response cycle
                RESPOND: if (!resp_valid_out) begin
                    resp_valid_out <= 1'b1;
                    cache_fill_out <= 1'b0;
                end else begin
                    state          <= IDLE;
                    resp_valid_out <= 1'b0;
                    resp_err_out   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
`ifdef CACHE_MISS_CTRL_STATS_EN
    always_ff @(posedge clock_in or posedge reset_in)
        if (reset_in) begin
            hit_cnt_out  <= 8'd0;
            miss_cnt_out <= 8'd0;
        end else if (state == LOOKUP) begin
            if (cache_hit_in) hit_cnt_out <= sat_inc(hit_cnt_out);
            else miss_cnt_out <= sat_inc(miss_cnt_out);
        end
`endif
endmodule

// File: tb/tb_cache_miss_ctrl.sv
// tb_cache_miss_ctrl: directed and randomized transactions checked against a latency/data model
module tb_cache_miss_ctrl;
    localparam int T = 15;
    logic       clock_in = 0, reset_in = 1;
    logic       req_valid_in = 0, req_wren_in = 0;
    logic [4:0] req_addr_in = 0;
    logic [7:0] req_data_in = 0;
    logic       req_ready_out, resp_valid_out, resp_err_out;
    logic [7:0] resp_data_out;
    logic       cache_hit_in = 0, cache_dirty_in = 0;
    logic [4:0] cache_victim_tag_in = 0;
    logic [7:0] cache_q_in = 0;
    logic       cache_lookup_out, cache_wren_out, cache_fill_out;
    logic [4:0] cache_addr_out;
    logic [7:0] cache_data_out;
    logic       mem_rd_out, mem_wr_out, mem_ack_in = 0;
    logic [4:0] mem_addr_out;
    logic [7:0] mem_data_out, mem_q_in = 0;
`ifdef CACHE_MISS_CTRL_STATS_EN
    logic [7:0] hit_cnt_out, miss_cnt_out;
`endif
    int passed = 0, total = 0;

    cache_miss_ctrl dut (
        .clock_in(clock_in), .reset_in(reset_in),
        .req_valid_in(req_valid_in), .req_wren_in(req_wren_in), .req_addr_in(req_addr_in),
        .req_data_in(req_data_in), .req_ready_out(req_ready_out), .resp_valid_out(resp_valid_out),
        .resp_data_out(resp_data_out), .resp_err_out(resp_err_out),
        .cache_hit_in(cache_hit_in), .cache_dirty_in(cache_dirty_in),
        .cache_victim_tag_in(cache_victim_tag_in), .cache_q_in(cache_q_in),
        .cache_lookup_out(cache_lookup_out), .cache_wren_out(cache_wren_out),
        .cache_fill_out(cache_fill_out), .cache_addr_out(cache_addr_out),
        .cache_data_out(cache_data_out), .mem_rd_out(mem_rd_out), .mem_wr_out(mem_wr_out),
        .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out), .mem_ack_in(mem_ack_in),
        .mem_q_in(mem_q_in)
`ifdef CACHE_MISS_CTRL_STATS_EN
        , .hit_cnt_out(hit_cnt_out), .miss_cnt_out(miss_cnt_out)
`endif
    );

    always #5 clock_in = ~clock_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // n1/n2: cycle of the write-back/fill strobe in which memory acks (0 = never)
    task automatic txn(input bit wr, input logic [4:0] a, input logic [7:0] d, input bit hit,
                       input bit dirty, input logic [4:0] vt, input logic [7:0] cq,
                       input int n1, input int n2, input logic [7:0] mq, input string tag);
        int lat = 0, nresp = 0, nlook = 0, nwren = 0, nfill = 0, nwr = 0, nrd = 0;
        int bad = 0, both = 0, rdy = 0;
        int elat, ewr, erd, efill;
        bit eerr, err = 0;
        logic [7:0] edat, rdat = 0, fdat = 0;
        if (hit) begin
            elat = 2; ewr = 0; erd = 0; efill = 0; eerr = 0;
            edat = wr ? d : cq;
        end else begin
            ewr = dirty ? (n1 == 0 ? T : n1) : 0;
            if (dirty && n1 == 0) begin
                erd = 0; efill = 0; eerr = 1; elat = 2 + T;
            end else begin
                erd = n2 == 0 ? T : n2;
                efill = n2 == 0 ? 0 : 1;
                eerr = n2 == 0;
                elat = 2 + ewr + erd + efill;
            end
            edat = wr ? d : mq;
        end
        @(negedge clock_in);
        chk({tag, ".ready"}, {31'b0, req_ready_out}, 1);
        req_valid_in = 1; req_wren_in = wr; req_addr_in = a; req_data_in = d;
        cache_hit_in = hit; cache_dirty_in = dirty; cache_victim_tag_in = vt; cache_q_in = cq;
        mem_q_in = mq; mem_ack_in = 0;
        @(posedge clock_in);
        #1 req_valid_in = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock_in);
            req_valid_in = 0;
            mem_ack_in = 0;
            if (mem_rd_out && mem_wr_out) both++;
            if (req_ready_out && nresp == 0) rdy++;
            if (nresp == 1 && c == lat + 1 && !req_ready_out) bad++;
            if (cache_lookup_out) begin
                nlook++;
                if (cache_addr_out !== a) bad++;
            end
            if (cache_wren_out) begin
                nwren++;
                if (cache_data_out !== d || cache_addr_out !== a) bad++;
            end
            if (cache_fill_out) begin
                nfill++;
                fdat = cache_data_out;
                if (cache_addr_out !== a) bad++;
            end
            if (mem_wr_out) begin
                nwr++;
                if (mem_addr_out !== vt || mem_data_out !== cq) bad++;
                if (nwr == n1) mem_ack_in = 1;
            end else if (mem_rd_out) begin
                nrd++;
                if (mem_addr_out !== a) bad++;
                if (nrd == n2) mem_ack_in = 1;
            end else mem_ack_in = 1'($urandom_range(0, 1));
            if (resp_valid_out) begin
                nresp++;
                if (nresp == 1) begin
                    lat = c; rdat = resp_data_out; err = resp_err_out;
                end
            end
            if (!req_ready_out) req_valid_in = 1'($urandom_range(0, 1));
        end
        req_valid_in = 0; mem_ack_in = 0;
        chk({tag, ".lat"}, lat, elat);
        chk({tag, ".nresp"}, nresp, 1);
        chk({tag, ".err"}, {31'b0, err}, {31'b0, eerr});
        if (!eerr) chk({tag, ".rdata"}, {24'b0, rdat}, {24'b0, edat});
        chk({tag, ".nlookup"}, nlook, 1);
        chk({tag, ".nwren"}, nwren, (hit && wr) ? 1 : 0);
        chk({tag, ".nfill"}, nfill, efill);
        if (efill == 1) chk({tag, ".fdata"}, {24'b0, fdat}, {24'b0, edat});
        chk({tag, ".nmemwr"}, nwr, ewr);
        chk({tag, ".nmemrd"}, nrd, erd);
        chk({tag, ".busaddr"}, bad, 0);
        chk({tag, ".rdwr_both"}, both, 0);
        chk({tag, ".ready_busy"}, rdy, 0);
    endtask

    initial begin
        int nr, nf, nm;
        #1;
        chk("rst.ready", {31'b0, req_ready_out}, 0);
        chk("rst.strobes", {26'b0, resp_valid_out, resp_err_out, cache_lookup_out,
            cache_fill_out, mem_rd_out, mem_wr_out}, 0);
        chk("rst.bus", {cache_addr_out, cache_data_out, mem_addr_out, mem_data_out[5:0]}, 0);
        chk("rst.rdata", {24'b0, resp_data_out}, 0);
        @(negedge clock_in);
        reset_in = 0;
        #1 chk("rst.ready_rel", {31'b0, req_ready_out}, 1);
        txn(0, 5'b10100, 8'h00, 1, 0, 5'h00, 8'h3C, 1, 1, 8'h00, "rd_hit");
        txn(1, 5'b10110, 8'hA5, 1, 0, 5'h00, 8'h00, 1, 1, 8'h00, "wr_hit");
        txn(0, 5'b11001, 8'h00, 0, 0, 5'h00, 8'h00, 1, 3, 8'h77, "clean_miss");
        txn(0, 5'b00011, 8'h00, 0, 1, 5'b10101, 8'h11, 2, 2, 8'h5A, "dirty_miss");
        txn(1, 5'b01110, 8'hC3, 0, 1, 5'b00110, 8'h22, 1, 1, 8'h99, "wr_dirty_min");
        txn(0, 5'b00111, 8'h00, 0, 0, 5'h00, 8'h00, 1, 0, 8'h00, "fill_tmo");
        txn(1, 5'b01001, 8'h3E, 0, 1, 5'b11111, 8'h44, 0, 1, 8'h00, "wb_tmo");
        for (int i = 0; i < 24; i++)
            txn(1'($urandom_range(0, 1)), 5'($urandom), 8'($urandom), $urandom_range(0, 2) == 0,
                1'($urandom_range(0, 1)), 5'($urandom), 8'($urandom),
                $urandom_range(0, 4), $urandom_range(0, 4), 8'($urandom), "rand");
        @(negedge clock_in);
        req_valid_in = 1; req_wren_in = 0; req_addr_in = 5'b01010;
        cache_hit_in = 0; cache_dirty_in = 0; mem_ack_in = 0;
        @(posedge clock_in);
        #1 req_valid_in = 0;
        repeat (5) @(negedge clock_in);
        chk("rstfill.in_fill", {31'b0, mem_rd_out}, 1);
        #2 reset_in = 1;
        #1;
        chk("rstfill.strobes", {25'b0, req_ready_out, resp_valid_out, resp_err_out,
            cache_lookup_out, cache_fill_out, mem_rd_out, mem_wr_out}, 0);
        chk("rstfill.bus", {cache_addr_out, cache_data_out, mem_addr_out, mem_data_out[5:0]}, 0);
        @(negedge clock_in);
        reset_in = 0;
        #1 chk("rstfill.ready", {31'b0, req_ready_out}, 1);
        nr = 0; nf = 0; nm = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock_in);
            mem_ack_in = 1'($urandom_range(0, 1));
            if (resp_valid_out) nr++;
            if (cache_fill_out) nf++;
            if (mem_rd_out || mem_wr_out || !req_ready_out) nm++;
        end
        mem_ack_in = 0;
        chk("rstfill.no_resp", nr, 0);
        chk("rstfill.no_fill", nf, 0);
        chk("rstfill.idle", nm, 0);
        txn(0, 5'b10100, 8'h00, 1, 0, 5'h00, 8'h5D, 1, 1, 8'h00, "post_rst_hit");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
